// File: rtl/ctrl_sequencer_if.sv
// Instruction handshake and registered control-word bundle between the
// instruction source and ctrl_sequencer.
interface ctrl_sequencer_if #(
  parameter int INSTR_W = 9
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               ctrl_valid;
  logic [4:0]         reg_op;
  logic [3:0]         reg_src;
  logic [3:0]         reg_dst;
  logic [3:0]         imm;
  logic               mem_sel;
  logic               alu_rs;
  logic [3:0]         math_op;
  logic               movp;

  modport master (
    output instr, instr_valid,
    input  instr_ready, ctrl_valid, reg_op, reg_src, reg_dst, imm,
           mem_sel, alu_rs, math_op, movp
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, ctrl_valid, reg_op, reg_src, reg_dst, imm,
           mem_sel, alu_rs, math_op, movp
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Run/halt sequencer: accepts instructions over valid/ready, emits one
// registered control word per instruction and stalls fetch for long ops.
module ctrl_sequencer #(
  parameter int INSTR_W = 9,
  parameter int MEM_LAT = 2,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  ctrl_sequencer_if.slave bus,
  output logic            busy_o,
  output logic            done_o
);
  localparam int MAX_LAT = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_HALT} state_e;
  typedef enum logic [4:0] {
    OP_NOP = 5'd0, OP_LOAD = 5'd1, OP_STORE = 5'd2, OP_INCR = 5'd3,
    OP_DECR = 5'd4, OP_JIZR = 5'd5, OP_JNZR = 5'd6, OP_BIZR = 5'd7,
    OP_BNZR = 5'd8, OP_SETH = 5'd9, OP_ALU = 5'd10, OP_LSLC = 5'd11,
    OP_LSRC = 5'd12, OP_FLIP = 5'd13, OP_LJP = 5'd14, OP_FUNC = 5'd15,
    OP_LIT_LO = 5'd16, OP_LIT_HI = 5'd17, OP_MOV = 5'd18
  } op_e;

  logic [1:0] cls_s, sub_s;
  logic       m_s;
  logic [3:0] lo_s;
  logic [2:0] lit_sel_s;

  assign cls_s     = bus.instr[INSTR_W-1 -: 2];
  assign sub_s     = bus.instr[INSTR_W-3 -: 2];
  assign m_s       = bus.instr[INSTR_W-5];
  assign lo_s      = bus.instr[3:0];
  assign lit_sel_s = bus.instr[INSTR_W-2 -: 3];

  op_e        dec_op_s;
  logic [3:0] dec_src_s, dec_dst_s, dec_imm_s, dec_math_s;
  logic       dec_mem_sel_s, dec_alu_rs_s, dec_movp_s;
  logic       dec_is_mem_s, dec_is_alu_s, dec_halt_s;

  // Instruction decode into control-word fields plus stall/halt class.
  always_comb begin
    dec_op_s      = OP_NOP;
    dec_src_s     = 4'd0;
    dec_dst_s     = 4'd0;
    dec_imm_s     = 4'd0;
    dec_math_s    = 4'd0;
    dec_mem_sel_s = 1'b0;
    dec_alu_rs_s  = 1'b0;
    dec_movp_s    = 1'b0;
    dec_is_mem_s  = 1'b0;
    dec_is_alu_s  = 1'b0;
    dec_halt_s    = 1'b0;
    case (cls_s)
      2'd2: begin
        case (sub_s)
          2'd0: begin
            dec_op_s      = m_s ? OP_STORE : OP_LOAD;
            dec_src_s     = m_s ? {1'b0, lo_s[2:0]} : 4'd0;
            dec_dst_s     = m_s ? 4'd0 : {1'b0, lo_s[2:0]};
            dec_mem_sel_s = lo_s[3];
            dec_is_mem_s  = 1'b1;
          end
          2'd1: begin
            dec_op_s  = m_s ? OP_DECR : OP_INCR;
            dec_dst_s = lo_s;
          end
          2'd2: dec_op_s = m_s ? OP_JNZR : OP_JIZR;
          2'd3: begin
            dec_op_s  = m_s ? OP_BNZR : OP_BIZR;
            dec_src_s = lo_s;
          end
          default: dec_op_s = OP_NOP;
        endcase
      end
      2'd3: begin
        case (sub_s)
          2'd0: begin
            dec_op_s  = OP_SETH;
            dec_imm_s = lo_s;
          end
          2'd1: begin
            dec_op_s     = OP_ALU;
            dec_alu_rs_s = m_s;
            dec_math_s   = lo_s;
            dec_is_alu_s = 1'b1;
          end
          2'd2: dec_op_s = m_s ? OP_LSRC : OP_LSLC;
          2'd3: begin
            // sub3/m1 multiplexes LJP, FUNC and the halt encoding on lo.
            if (!m_s) begin
              dec_op_s  = OP_FLIP;
              dec_imm_s = lo_s;
            end else if (lo_s <= 4'd3) begin
              dec_op_s  = OP_LJP;
              dec_imm_s = lo_s;
            end else if ((lo_s == 4'd12) || (lo_s == 4'd13)) begin
              dec_op_s = OP_FUNC;
            end else begin
              dec_halt_s = 1'b1;
            end
          end
          default: dec_op_s = OP_NOP;
        endcase
      end
      default: begin
        if (lit_sel_s == 3'd0) begin
          dec_op_s  = m_s ? OP_LIT_HI : OP_LIT_LO;
          dec_imm_s = lo_s;
        end else begin
          dec_op_s   = OP_MOV;
          dec_dst_s  = bus.instr[7:4];
          dec_src_s  = lo_s;
          dec_movp_s = (bus.instr[7:4] == 4'hF);
        end
      end
    endcase
  end

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               start_q, accept_s;

  assign accept_s = (state_q == S_DECODE) && bus.instr_valid;

  // Next-state and stall-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_DECODE;
        else         state_d = S_IDLE;
      end
      S_DECODE: begin
        if (!accept_s) begin
          state_d = S_DECODE;
        end else if (dec_halt_s) begin
          state_d = S_HALT;
        end else if (dec_is_mem_s && (MEM_LAT > 1)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else if (dec_is_alu_s && (ALU_LAT > 1)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(ALU_LAT - 1);
        end else begin
          state_d = S_DECODE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_DECODE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HALT: begin
        if (start_i && !start_q) state_d = S_HALT == S_HALT ? S_DECODE : S_HALT;
        else                     state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic       ready_q, busy_q, done_q, valid_q;
  op_e        op_q;
  logic [3:0] src_q, dst_q, imm_q, math_q;
  logic       mem_sel_q, alu_rs_q, movp_q;

  // State, handshake flags and the one-cycle control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      op_q      <= OP_NOP;
      src_q     <= 4'd0;
      dst_q     <= 4'd0;
      imm_q     <= 4'd0;
      math_q    <= 4'd0;
      mem_sel_q <= 1'b0;
      alu_rs_q  <= 1'b0;
      movp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_i;
      ready_q   <= (state_d == S_DECODE);
      busy_q    <= (state_d == S_DECODE) || (state_d == S_WAIT);
      done_q    <= (state_d == S_HALT);
      valid_q   <= accept_s;
      op_q      <= accept_s ? dec_op_s      : OP_NOP;
      src_q     <= accept_s ? dec_src_s     : 4'd0;
      dst_q     <= accept_s ? dec_dst_s     : 4'd0;
      imm_q     <= accept_s ? dec_imm_s     : 4'd0;
      math_q    <= accept_s ? dec_math_s    : 4'd0;
      mem_sel_q <= accept_s ? dec_mem_sel_s : 1'b0;
      alu_rs_q  <= accept_s ? dec_alu_rs_s  : 1'b0;
      movp_q    <= accept_s ? dec_movp_s    : 1'b0;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.ctrl_valid  = valid_q;
  assign bus.reg_op      = op_q;
  assign bus.reg_src     = src_q;
  assign bus.reg_dst     = dst_q;
  assign bus.imm         = imm_q;
  assign bus.math_op     = math_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.alu_rs      = alu_rs_q;
  assign bus.movp        = movp_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
endmodule
